// File: rtl/branch_predictor_bank_pkg.sv
// branch_predictor_bank_pkg: shared predictor counter encoding and reset value
package branch_predictor_bank_pkg;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } predictor_state;
  localparam logic [1:0] PHT_INIT = WEAK_NT;
endpackage

// File: rtl/branch_predictor_bank_sat_counter2.sv
// sat_counter2: 2-bit saturating counter, async reset to weakly not taken
module sat_counter2
  import branch_predictor_bank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= PHT_INIT;
    else if (inc && cnt != STRONG_T) cnt <= cnt + 2'd1;
    else if (dec && cnt != STRONG_NT) cnt <= cnt - 2'd1;
endmodule

// File: rtl/branch_predictor_bank.sv
// branch_predictor_bank: PHT + direct-mapped BTB predictor, optional gshare, trained from the resolve port
module branch_predictor_bank
  import branch_predictor_bank_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int HIST_LEN    = 6,
  parameter int GSHARE      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_is_jal,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] mispredict_count
);
  localparam int PHT_IDX = $clog2(PHT_ENTRIES);
  localparam int BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W   = 30 - BTB_IDX;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_jal;
  } btb_entry_t;
  btb_entry_t btb [BTB_ENTRIES];
  btb_entry_t fe;
  logic [HIST_LEN-1:0] ghr;
  logic [PHT_IDX-1:0] hist, f_idx, u_idx;
  logic [1:0] cnt [PHT_ENTRIES];
  logic br_upd, jal_upd;
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};
  assign hist    = GSHARE != 0 ? PHT_IDX'(ghr) : '0;
  assign f_idx   = fetch_pc[PHT_IDX+1:2] ^ hist;
  assign u_idx   = upd_pc[PHT_IDX+1:2] ^ hist;
  // a simultaneous br+jal is handled as jal
  assign jal_upd = upd_valid && upd_is_jal;
  assign br_upd  = upd_valid && upd_is_br && !upd_is_jal;
  for (genvar g = 0; g < PHT_ENTRIES; g++) begin : g_pht
    sat_counter2 u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (br_upd && u_idx == PHT_IDX'(g) && upd_taken),
      .dec   (br_upd && u_idx == PHT_IDX'(g) && !upd_taken),
      .cnt   (cnt[g])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    else if (jal_upd || (br_upd && upd_taken))
      btb[upd_pc[BTB_IDX+1:2]] <= '{valid: 1'b1, tag: upd_pc[31:BTB_IDX+2], target: upd_target, is_jal: jal_upd};
  always_ff @(posedge clk or posedge reset)
    if (reset) ghr <= '0;
    else if (br_upd) ghr <= HIST_LEN'({ghr, upd_taken});
  always_ff @(posedge clk or posedge reset)
    if (reset) mispredict_count <= '0;
    else if (upd_valid && upd_mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
  always_comb begin
    fe          = btb[fetch_pc[BTB_IDX+1:2]];
    pred_hit    = fe.valid && fe.tag == fetch_pc[31:BTB_IDX+2];
    pred_taken  = pred_hit && (fe.is_jal || cnt[f_idx][1]);
    pred_target = pred_hit ? fe.target : '0;
  end
  always @(posedge clk)
    if (!reset && upd_valid) assert (!(upd_is_br && upd_is_jal));
endmodule

// File: tb/tb_branch_predictor_bank.sv
// tb_branch_predictor_bank: bimodal and gshare instances checked against an array-based reference model
module tb_branch_predictor_bank;
  logic clk = 0, reset = 1;
  logic [31:0] fetch_pc = 0, upd_pc = 0, upd_target = 0;
  logic upd_valid = 0, upd_is_br = 0, upd_is_jal = 0, upd_taken = 0, upd_mispredict = 0;
  logic ph [2], pt [2];
  logic [31:0] pg [2], mc [2];
  int n_chk = 0, n_fail = 0;
  int pht [2][64];
  bit bv [2][16], bj [2][16];
  int unsigned bt [2][16], bg [2][16];
  int ghr [2];
  longint unsigned mcnt;

  always #5 clk = ~clk;

  branch_predictor_bank d0 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pt[0]), .pred_target(pg[0]),
    .pred_hit(ph[0]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
    .upd_is_jal(upd_is_jal), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mc[0]));
  branch_predictor_bank #(.HIST_LEN(2), .GSHARE(1)) d1 (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pt[1]), .pred_target(pg[1]),
    .pred_hit(ph[1]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
    .upd_is_jal(upd_is_jal), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mc[1]));

  function automatic int pidx(int m, logic [31:0] pc);
    return ((pc >> 2) & 63) ^ (m == 1 ? (ghr[1] & 3) : 0);
  endfunction

  function automatic bit m_hit(int m, logic [31:0] pc);
    int b = (pc >> 2) & 15;
    return bv[m][b] && bt[m][b] == (pc >> 6);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) pht[m][i] = 1;
      for (int i = 0; i < 16; i++) bv[m][i] = 0;
      ghr[m] = 0;
    end
    mcnt = 0;
  endtask

  task automatic model_upd();
    for (int m = 0; m < 2; m++) begin
      int b = (upd_pc >> 2) & 15;
      if (upd_is_jal || (upd_is_br && upd_taken)) begin
        bv[m][b] = 1; bt[m][b] = upd_pc >> 6; bg[m][b] = upd_target; bj[m][b] = upd_is_jal;
      end
      if (upd_is_br && !upd_is_jal) begin
        int i = pidx(m, upd_pc);
        pht[m][i] = upd_taken ? (pht[m][i] < 3 ? pht[m][i] + 1 : 3) : (pht[m][i] > 0 ? pht[m][i] - 1 : 0);
        ghr[m] = ((ghr[m] << 1) | int'(upd_taken)) & (m == 1 ? 3 : 63);
      end
    end
    if (upd_mispredict && mcnt < 64'hFFFF_FFFF) mcnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    fetch_pc = pc;
    #1;
    for (int m = 0; m < 2; m++) begin
      bit h = m_hit(m, pc);
      int b = (pc >> 2) & 15;
      chk($sformatf("hit%0d@%h", m, pc), 32'(ph[m]), 32'(h));
      chk($sformatf("taken%0d@%h", m, pc), 32'(pt[m]), 32'(h && (bj[m][b] || pht[m][pidx(m, pc)] >= 2)));
      chk($sformatf("target%0d@%h", m, pc), pg[m], h ? bg[m][b] : 32'h0);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit br, input bit jal, input bit tk,
                       input logic [31:0] tgt, input bit mis);
    upd_valid = 1; upd_pc = pc; upd_is_br = br; upd_is_jal = jal;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
  endtask

  task automatic commit();
    model_upd();
    #1 upd_valid = 0; upd_mispredict = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit br, input bit jal, input bit tk,
                     input logic [31:0] tgt, input bit mis);
    @(negedge clk);
    drive(pc, br, jal, tk, tgt, mis);
    @(posedge clk);
    commit();
  endtask

  initial begin
    logic [31:0] pcs [6];
    model_reset();
    fetch_pc = 32'h60;
    #1;
    chk("rst_hit", 32'(ph[0]), 0);
    chk("rst_taken", 32'(pt[0]), 0);
    chk("rst_target", pg[0], 0);
    chk("rst_mcnt", mc[0], 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    look(32'h60);
    upd(32'h100, 1, 0, 1, 32'h140, 0);
    upd(32'h100, 1, 0, 1, 32'h140, 0);
    look(32'h100);
    chk("bim_taken_const", 32'(pt[0]), 1);
    chk("bim_target_const", pg[0], 32'h140);
    for (int i = 0; i < 3; i++) upd(32'h100, 1, 0, 0, 32'h0, 0);
    look(32'h100);
    chk("bim_nt_const", 32'(pt[0]), 0);
    chk("bim_hit_kept", 32'(ph[0]), 1);
    for (int i = 0; i < 10; i++) upd(32'h100, 1, 0, 0, 32'h0, 0);
    upd(32'h100, 1, 0, 1, 32'h140, 0);
    look(32'h100);
    chk("bim_sat_low", 32'(pt[0]), 0);
    upd(32'h200, 0, 1, 0, 32'h80, 0);
    look(32'h200);
    chk("jal_taken_const", 32'(pt[0]), 1);
    chk("jal_target_const", pg[0], 32'h80);
    upd(32'h100, 1, 0, 1, 32'h140, 0);
    upd(32'h140, 1, 0, 1, 32'h180, 0);
    look(32'h100);
    chk("btb_replace_const", 32'(ph[0]), 0);
    look(32'h140);
    for (int i = 0; i < 8; i++) begin
      upd(32'h300, 1, 0, i % 2 == 0, 32'h340, 0);
      look(32'h300);
    end
    for (int i = 0; i < 6; i++) begin
      upd(32'h300, 1, 0, i % 2 == 0, 32'h340, 0);
      look(32'h300);
    end
    @(negedge clk);
    drive(32'h140, 1, 0, 0, 32'h0, 0);
    look(32'h140);
    @(posedge clk);
    commit();
    look(32'h140);
    upd(32'h400, 1, 0, 1, 32'h500, 1);
    upd(32'h404, 0, 1, 0, 32'h600, 1);
    upd(32'h408, 0, 0, 1, 32'h700, 1);
    #1;
    chk("mcnt3_d0", mc[0], 3);
    chk("mcnt3_d1", mc[1], 3);
    @(negedge clk);
    drive(32'h408, 1, 0, 1, 32'h900, 1);
    #2 reset = 1;
    model_reset();
    #1;
    chk("async_mcnt", mc[0], 0);
    look(32'h400);
    look(32'h140);
    @(negedge clk);
    upd_valid = 0; upd_mispredict = 0;
    reset = 0;
    look(32'h408);
    chk("post_rst_mcnt", mc[1], 0);
    pcs = '{32'h100, 32'h140, 32'h200, 32'h300, 32'h304, 32'h0};
    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 2);
      logic [31:0] pc;
      pcs[5] = {$urandom_range(0, 255), 2'b00};
      pc = pcs[$urandom_range(0, 5)];
      upd(pc, k == 0, k == 1, 1'($urandom_range(0, 1)), {$urandom, 2'b00} & 32'hFFFF_FFFC,
          $urandom_range(0, 7) == 0);
      look(pcs[$urandom_range(0, 5)]);
      if (i % 50 == 0) chk("rand_mcnt", mc[0], 32'(mcnt));
    end
    chk("final_mcnt", mc[1], 32'(mcnt));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
